// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line/clock rates, bit-period helper and receiver FSM states.
package uart_rx_pkg;

  localparam int DEF_UART_BPS = 115200;
  localparam int DEF_CLK_FREQ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit; uart_tx uses the same formula so both ends agree on the bit period.
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_sync_fall.sv
// Two-flop synchroniser for an asynchronous, idle-high input, plus a registered
// delay stage that yields a one-cycle falling-edge strobe.
module uart_sync_fall (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // NOTE: all three stages reset to the idle level (1) so leaving reset can never
  // look like a falling edge and launch a phantom start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_dly  <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_dly & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit data sampling,
// one-cycle done pulse for a good byte and one-cycle frame_err pulse for a low stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int UART_BPS = DEF_UART_BPS,
  parameter int CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_busy,
  output logic       uart_frame_err
);

  localparam int          BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int          HALF_BIT     = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BD_LAST      = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  logic w_rxd_s;
  logic w_fall;

  uart_sync_fall u_sync_fall (
    .clk     (clk),
    .rst     (rst),
    .i_async (uart_rxd),
    .o_sync  (w_rxd_s),
    .o_fall  (w_fall)
  );

  rx_state_t   r_state;
  logic [15:0] r_bd_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_data;
  logic        r_done;
  logic        r_busy;
  logic        r_err;

  // NOTE: every register in this block uses <= so each branch reads the values from
  // before the edge; blocking assignments here would let later lines see updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bd_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state  <= START;
            r_bd_cnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (r_bd_cnt == HALF_LAST) begin
            r_bd_cnt <= '0;
            if (!w_rxd_s) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else begin
              // Line already high again at start-bit centre: treat as a glitch.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_bd_cnt <= r_bd_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_bd_cnt == BD_LAST) begin
            r_bd_cnt  <= '0;
            r_shreg   <= {w_rxd_s, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
          end else begin
            r_bd_cnt <= r_bd_cnt + 16'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught with no gap.
          if (r_bd_cnt == BD_LAST) begin
            r_bd_cnt <= '0;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            if (w_rxd_s) begin
              r_data <= r_shreg;
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_bd_cnt <= r_bd_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_rx_data   = r_data;
  assign uart_rx_done   = r_done;
  assign uart_rx_busy   = r_busy;
  assign uart_frame_err = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a bench-side serial transmitter drives the line and a
// frame-level model predicts every done/err pulse, its byte and its arrival cycle.
module tb_uart_rx;

  localparam int MAX  = 50_000_000 / 115200;   // 434 clocks per bit
  localparam int HALF = MAX / 2;                // 217
  localparam int LAT  = 2 + HALF + 9 * MAX + 1; // pin start edge -> done/err visible

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  uart_rx #(.UART_BPS(115200), .CLK_FREQ(50_000_000)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rxd       (rxd),
    .uart_rx_data   (data),
    .uart_rx_done   (done),
    .uart_rx_busy   (busy),
    .uart_frame_err (err)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  int         cyc = 0;
  ev_t        ev_q[$];
  ev_t        exp_q[$];
  int         both_cnt = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] exp_data;
  int         t_fall;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulses, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      ev_q.push_back('{err: (err === 1'b1), data: data, cyc: cyc});
      if (done === 1'b1 && err === 1'b1) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int want, input int tol);
    n_vec++;
    assert (obs >= want - tol && obs <= want + tol) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, want, tol);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Transmit one 8N1 frame with bclk clocks per bit and record the predicted outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int bclk);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (i == 0) t_fall = cyc;
      repeat (bclk) @(negedge clk);
    end
    if (stop_b) exp_data = b;
    e.err  = !stop_b;
    e.data = exp_data;
    e.cyc  = t_fall + LAT;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "/count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "/kind"}, 32'(ev_q[i].err), 32'(exp_q[i].err));
      chk({tag, "/data"}, 32'(ev_q[i].data), 32'(exp_q[i].data));
      chk_tol({tag, "/latency"}, ev_q[i].cyc, exp_q[i].cyc, 2);
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] ab;
    logic [9:0] abits;
    logic [7:0] rb;
    int         busy_cycles;

    rst      = 1'b1;
    rxd      = 1'b1;
    exp_data = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst/data", 32'(data), 32'h00);
    chk("rst/done", 32'(done), 0);
    chk("rst/busy", 32'(busy), 0);
    chk("rst/err", 32'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst/busy", 32'(busy), 0);

    // Two ordinary frames.
    send_frame(8'h55, 1'b1, MAX); idle(MAX);
    send_frame(8'hA3, 1'b1, MAX); idle(MAX);
    check_events("loopback");

    // Back-to-back frames with no idle time between stop and start.
    send_frame(8'h00, 1'b1, MAX);
    send_frame(8'hFF, 1'b1, MAX);
    send_frame(8'h81, 1'b1, MAX);
    idle(MAX);
    if (ev_q.size() >= 3) begin
      chk_tol("b2b/spacing01", ev_q[1].cyc - ev_q[0].cyc, 10 * MAX, 2);
      chk_tol("b2b/spacing12", ev_q[2].cyc - ev_q[1].cyc, 10 * MAX, 2);
    end
    check_events("b2b");

    // 100-clock low glitch: busy for about half a bit, then nothing.
    busy_cycles = 0;
    rxd = 1'b0;
    for (int i = 0; i < 100 + MAX; i++) begin
      if (i == 100) rxd = 1'b1;
      @(negedge clk);
      busy_cycles += int'(busy);
    end
    chk_tol("glitch/busy_cycles", busy_cycles, HALF, 2);
    check_events("glitch");

    // Low stop bit: frame error, held byte unchanged.
    send_frame(8'h3C, 1'b0, MAX); idle(MAX);
    check_events("stop_low");

    // Break: line stays low well past the frame; exactly one error.
    send_frame(8'h00, 1'b0, MAX);
    repeat (4 * MAX) @(negedge clk);
    idle(2 * MAX);
    check_events("break");

    // Reset pulse in the middle of data bit 4 aborts the frame silently.
    ab    = 8'($urandom);
    abits = {1'b1, ab, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = abits[i];
      repeat (MAX) @(negedge clk);
    end
    rxd = abits[5];
    repeat (HALF) @(negedge clk);
    chk("abort/busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    exp_data = 8'h00;
    chk("abort/busy", 32'(busy), 0);
    chk("abort/data", 32'(data), 32'h00);
    chk("abort/done", 32'(done), 0);
    chk("abort/err", 32'(err), 0);
    idle(2 * MAX);
    check_events("abort");
    send_frame(8'h5A, 1'b1, MAX); idle(MAX);
    check_events("after_abort");

    // Transmitter running 3% fast, then 3% slow.
    send_frame(8'hC7, 1'b1, 421); idle(MAX);
    send_frame(8'hC7, 1'b1, 447); idle(MAX);
    check_events("skew");

    // Random bytes, rates within +/-2% and random idle gaps.
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, MAX - 8 + int'($urandom_range(0, 16)));
      idle(int'($urandom_range(1, MAX)));
    end
    idle(MAX);
    check_events("random");

    chk("done_err_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
